// File: rtl/clock_div_sched_pkg.sv
// Shared definitions for the clock_div_sched block.
//   state_t  : FSM state encoding (IDLE, RUN, PEND)
//   MIN_DIV  : smallest divisor accepted by a div_req
//   PCOUNT_W : width of the optional period counter output
package clock_div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int MIN_DIV  = 2;
  localparam int PCOUNT_W = 16;

endpackage

// File: rtl/clock_div_sched_period_cnt.sv
// Period counter for clock_div_sched.
// Counts 0..n-1 while count is high and returns to 0 on wrap or when count
// is low. The next count value is exported so the parent can register
// outputs that line up with the counter value.
// Ports:
//   clk_in  : clock, rising edge
//   rst     : synchronous active-low reset
//   count   : keep counting this cycle (block running and enabled)
//   n       : current divisor
//   cnt_nx  : counter value for the next cycle
//   wrap    : current cycle is the last one of the period (cnt == n-1)
module div_period_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             count,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] cnt_nx,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;

  assign wrap   = (cnt == n - WIDTH'(1));
  assign cnt_nx = (count && !wrap) ? cnt + WIDTH'(1) : '0;

  always_ff @(posedge clk_in) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nx;
  end

endmodule

// File: rtl/clock_div_sched.sv
// Programmable clock divider with glitch-free divisor scheduling.
// A new divisor requested while running is held in a shadow register and
// applied only at the end of the current period, so no period is cut short.
// Optional feature: define CLOCK_DIV_SCHED_PCOUNT_EN to add the pcount output.
// Ports:
//   clk_in  : system clock, rising edge
//   rst     : synchronous active-low reset
//   en      : run enable
//   div_req : request to load div_val as the divisor
//   div_val : requested divisor (period in clk_in cycles)
//   div_ack : pulse on the cycle the new divisor takes effect
//   busy    : a divisor is pending (shadow register in use)
//   err     : pulse after a rejected request (div_val < 2)
//   clk_out : divided clock, registered
//   pulse   : strobe on the last cycle of each period, registered
//   pcount  : (optional) number of periods completed, wraps at 16 bits
module clock_div_sched
  import clock_div_sched_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic             err,
  output logic             clk_out,
  output logic             pulse
`ifdef CLOCK_DIV_SCHED_PCOUNT_EN
  ,
  output logic [PCOUNT_W-1:0] pcount
`endif
);

  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  state_t           state, state_nx;
  logic [WIDTH-1:0] n, n_nx;
  logic [WIDTH-1:0] shadow, shadow_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic             wrap;
  logic             accept, reject;
  logic             ack_q, ack_nx;
  logic             apply_now;

  // ceil(v/2): number of high cycles of clk_out for divisor v
  function automatic logic [WIDTH:0] half_up(input logic [WIDTH-1:0] v);
    return ({1'b0, v} + (WIDTH+1)'(1)) >> 1;
  endfunction

  div_period_cnt #(.WIDTH(WIDTH)) u_period (
    .clk_in (clk_in),
    .rst    (rst),
    .count  ((state != IDLE) && en),
    .n      (n),
    .cnt_nx (cnt_nx),
    .wrap   (wrap)
  );

  assign busy   = (state == PEND);
  assign accept = div_req && !busy && (div_val >= MIN_DIV_W);
  assign reject = div_req && !busy && (div_val <  MIN_DIV_W);

  // Shadow application is acknowledged in the cycle it happens (wrap or en
  // falling); immediate loads from a stopped divider are acknowledged one
  // cycle later through ack_q. A cycle under reset never acknowledges.
  assign div_ack = ack_q | (apply_now & rst);

  always_comb begin
    state_nx  = state;
    n_nx      = n;
    shadow_nx = shadow;
    ack_nx    = 1'b0;
    apply_now = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          n_nx   = div_val;
          ack_nx = 1'b1;
        end
        if (en) state_nx = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
          if (accept) begin
            n_nx   = div_val;
            ack_nx = 1'b1;
          end
        end else if (accept) begin
          shadow_nx = div_val;
          state_nx  = PEND;
        end
      end
      PEND: begin
        if (!en || wrap) begin
          n_nx      = shadow;
          apply_now = 1'b1;
          state_nx  = en ? RUN : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from next-cycle values so they line up with cnt.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state   <= IDLE;
      n       <= WIDTH'(DEFAULT_DIV);
      shadow  <= '0;
      ack_q   <= 1'b0;
      err     <= 1'b0;
      clk_out <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state   <= state_nx;
      n       <= n_nx;
      shadow  <= shadow_nx;
      ack_q   <= ack_nx;
      err     <= reject;
      clk_out <= (state_nx != IDLE) && ({1'b0, cnt_nx} < half_up(n_nx));
      pulse   <= (state_nx != IDLE) && (cnt_nx == n_nx - WIDTH'(1));
    end
  end

`ifdef CLOCK_DIV_SCHED_PCOUNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst)       pcount <= '0;
    else if (pulse) pcount <= pcount + PCOUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_clock_div_sched.sv
// Directed testbench for clock_div_sched (WIDTH=8, DEFAULT_DIV=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_clock_div_sched;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       busy;
  logic       err;
  logic       clk_out;
  logic       pulse;
`ifdef CLOCK_DIV_SCHED_PCOUNT_EN
  logic [15:0] pcount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  clock_div_sched #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .busy    (busy),
    .err     (err),
    .clk_out (clk_out),
    .pulse   (pulse)
`ifdef CLOCK_DIV_SCHED_PCOUNT_EN
    ,
    .pcount  (pcount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Starting on a cnt=0 cycle, check one full period of divisor n.
  task automatic run_period(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_clk"},   32'(clk_out), 32'(i < (n + 1) / 2));
      check({tag, "_pulse"}, 32'(pulse),   32'(i == n - 1));
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 8'd0;

    // reset state
    tick(); tick();
    check("rst_clk",  32'(clk_out), 0);
    check("rst_pulse",32'(pulse),   0);
    check("rst_ack",  32'(div_ack), 0);
    check("rst_busy", 32'(busy),    0);
    check("rst_err",  32'(err),     0);

    // default divisor 2: clk_out toggles each cycle, pulse every 2nd cycle
    rst = 1'b1; en = 1'b1;
    tick();
    run_period(2, "n2a"); run_period(2, "n2b"); run_period(2, "n2c");

    // load 5 in IDLE, then run: 3 high / 2 low
    en = 1'b0;
    tick();
    check("idle_clk", 32'(clk_out), 0);
    check("idle_pulse", 32'(pulse), 0);
    div_req = 1'b1; div_val = 8'd5;
    tick();
    check("idle_ack", 32'(div_ack), 1);
    check("idle_busy", 32'(busy), 0);
    div_req = 1'b0; en = 1'b1;
    tick();
    check("idle_ack_once", 32'(div_ack), 0);
    run_period(5, "n5a"); run_period(5, "n5b");

    // N=4 running, request 6 while at cnt=0: busy cnt 1..3, ack at cnt=3
    en = 1'b0; tick();
    div_req = 1'b1; div_val = 8'd4; tick();
    div_req = 1'b0; en = 1'b1; tick();
    div_req = 1'b1; div_val = 8'd6;
    tick();
    div_req = 1'b0;
    check("p4_c1_busy", 32'(busy), 1);
    check("p4_c1_ack",  32'(div_ack), 0);
    check("p4_c1_clk",  32'(clk_out), 1);
    tick();
    check("p4_c2_busy", 32'(busy), 1);
    check("p4_c2_clk",  32'(clk_out), 0);
    tick();
    check("p4_c3_busy", 32'(busy), 1);
    check("p4_c3_ack",  32'(div_ack), 1);
    check("p4_c3_pulse",32'(pulse), 1);
    tick();
    check("p6_busy", 32'(busy), 0);
    check("p6_ack",  32'(div_ack), 0);
    run_period(6, "n6a");

    // illegal divisor: err once, busy low, divisor unchanged
    en = 1'b0; tick();
    div_req = 1'b1; div_val = 8'd1;
    tick();
    div_req = 1'b0;
    check("rej_err",  32'(err), 1);
    check("rej_busy", 32'(busy), 0);
    check("rej_ack",  32'(div_ack), 0);
    tick();
    check("rej_err_once", 32'(err), 0);
    en = 1'b1; tick();
    run_period(6, "n6b");

    // second request while busy is ignored: 3 applies, not 7
    div_req = 1'b1; div_val = 8'd3;
    tick();
    check("ign_busy1", 32'(busy), 1);
    div_val = 8'd7;
    tick();
    div_req = 1'b0;
    check("ign_err", 32'(err), 0);
    check("ign_busy2", 32'(busy), 1);
    tick(); tick(); tick();
    check("ign_ack", 32'(div_ack), 1);
    tick();
    run_period(3, "n3a"); run_period(3, "n3b");

    // en falls with 5 pending: ack on the way to IDLE, 5 used on restart
    div_req = 1'b1; div_val = 8'd5;
    tick();
    div_req = 1'b0; en = 1'b0;
    #1;
    check("enf_ack", 32'(div_ack), 1);
    tick();
    check("enf_clk",  32'(clk_out), 0);
    check("enf_pulse",32'(pulse), 0);
    check("enf_busy", 32'(busy), 0);
    check("enf_ack_off", 32'(div_ack), 0);
    en = 1'b1; tick();
    run_period(5, "n5c");

    // reset mid-run with 9 pending: discarded, back to divisor 2
    div_req = 1'b1; div_val = 8'd9;
    tick();
    div_req = 1'b0;
    check("mr_busy_pre", 32'(busy), 1);
    rst = 1'b0;
    tick();
    check("mr_clk",  32'(clk_out), 0);
    check("mr_pulse",32'(pulse), 0);
    check("mr_ack",  32'(div_ack), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_err",  32'(err), 0);
    rst = 1'b1;
    tick();
    run_period(2, "n2d"); run_period(2, "n2e");

    // request accepted on a wrap cycle applies at the following wrap
    tick();
    check("wr_pulse", 32'(pulse), 1);
    div_req = 1'b1; div_val = 8'd4;
    tick();
    div_req = 1'b0;
    check("wr_c0_busy", 32'(busy), 1);
    check("wr_c0_clk",  32'(clk_out), 1);
    check("wr_c0_ack",  32'(div_ack), 0);
    tick();
    check("wr_c1_pulse",32'(pulse), 1);
    check("wr_c1_ack",  32'(div_ack), 1);
    tick();
    check("wr_busy_clr",32'(busy), 0);
    run_period(4, "n4a");

`ifdef CLOCK_DIV_SCHED_PCOUNT_EN
    rst = 1'b0; tick();
    check("pc_rst", 32'(pcount), 0);
    rst = 1'b1; en = 1'b1; tick();
    repeat (20) tick();
    check("pc_ten", 32'(pcount), 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
